// File: rtl/useq_pkg.sv
// Shared useq definitions: bridge state encoding and the core byte width.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package useq_pkg;

    // Width of one message byte on both the host and the core side.
    localparam int BYTE_W = 8;

    // Bridge state encoding; values are fixed because useq-side tooling decodes them.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        RCAP = 3'd3,
        GAP  = 3'd4
    } bridge_state_t;

    // Last serviced operation, used for round-robin between write and read.
    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_t;

    // Number of idle cycles actually spent in GAP (never less than one).
    function automatic int gap_cycles(input int poll_gap);
        return (poll_gap < 1) ? 1 : poll_gap;
    endfunction

endpackage

// File: rtl/useq_fifo_bridge.sv
// Bridges a host valid/ready byte stream to the useq core message FIFO strobes.
// Latency: write strobe 1 cycle after s_valid&s_ready; m_valid 2 cycles after the read strobe.
// Backpressure: s_ready low while busy or fifo_full; no read while hold register is full.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   s_data/s_valid/s_ready      host-to-core byte stream
//   m_data/m_valid/m_ready      core-to-host byte stream
//   write_fifo/read_fifo        registered single-cycle strobes to the core FIFO
//   fifo_in/fifo_out            byte written to / read from the core FIFO
//   fifo_empty/fifo_full        core FIFO flags (lag a strobe by one cycle)
//   busy                        high whenever the bridge is not in IDLE
//
// Build option: define USEQ_BRIDGE_READ_EN to include the core-to-host read path.
// Without it the m_* outputs and read_fifo are tied low and only writes are arbitrated.
module useq_fifo_bridge
    import useq_pkg::*;
#(
    parameter int POLL_GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              write_fifo,
    output logic              read_fifo,
    output logic [BYTE_W-1:0] fifo_in,
    input  logic [BYTE_W-1:0] fifo_out,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    output logic              busy
);

    localparam int GAP_N = gap_cycles(POLL_GAP);
    localparam int CNT_W = ($clog2(POLL_GAP + 1) < 1) ? 1 : $clog2(POLL_GAP + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_N);

    bridge_state_t    state;
    op_t              last_op;
    logic [CNT_W-1:0] gap_cnt;
    logic             wr_cand;
    logic             rd_cand;
    logic             sel_wr;

`ifdef USEQ_BRIDGE_READ_EN
    logic              hold_valid;
    logic [BYTE_W-1:0] hold_data;
    logic              sel_rd;
`endif

    // Arbitration between a pending host byte and a readable core byte.
    // When both are possible the op not taken last time wins; reset favours write.
    always_comb begin
        wr_cand = s_valid & ~fifo_full;
`ifdef USEQ_BRIDGE_READ_EN
        rd_cand = ~hold_valid & ~fifo_empty;
`else
        rd_cand = 1'b0;
`endif
        sel_wr  = wr_cand & (~rd_cand | (last_op == OP_RD));
`ifdef USEQ_BRIDGE_READ_EN
        sel_rd  = rd_cand & ~sel_wr;
`endif
    end

    assign s_ready = (state == IDLE) & sel_wr;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            write_fifo <= 1'b0;
            fifo_in    <= '0;
            last_op    <= OP_RD;
            gap_cnt    <= '0;
`ifdef USEQ_BRIDGE_READ_EN
            read_fifo  <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
`endif
        end else begin
`ifdef USEQ_BRIDGE_READ_EN
            // Host pop can happen in any state; RCAP only runs with the register
            // empty, so its set below never collides with this clear.
            if (hold_valid && m_ready) begin
                hold_valid <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (sel_wr) begin
                        fifo_in    <= s_data;
                        write_fifo <= 1'b1;
                        last_op    <= OP_WR;
                        state      <= WR;
                    end
`ifdef USEQ_BRIDGE_READ_EN
                    else if (sel_rd) begin
                        read_fifo <= 1'b1;
                        last_op   <= OP_RD;
                        state     <= RD;
                    end
`endif
                end
                WR: begin
                    write_fifo <= 1'b0;
                    gap_cnt    <= GAP_LOAD;
                    state      <= GAP;
                end
`ifdef USEQ_BRIDGE_READ_EN
                RD: begin
                    read_fifo <= 1'b0;
                    state     <= RCAP;
                end
                RCAP: begin
                    // The core registers fifo_out one cycle after the strobe.
                    hold_data  <= fifo_out;
                    hold_valid <= 1'b1;
                    gap_cnt    <= GAP_LOAD;
                    state      <= GAP;
                end
`endif
                GAP: begin
                    // Also absorbs the one-cycle lag of fifo_empty/fifo_full.
                    if (gap_cnt <= CNT_W'(1)) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef USEQ_BRIDGE_READ_EN
    assign m_valid = hold_valid;
    assign m_data  = hold_data;
`else
    assign read_fifo = 1'b0;
    assign m_valid   = 1'b0;
    assign m_data    = '0;

    // Read-side inputs stay on the port list for pin compatibility only.
    logic unused_rd;
    assign unused_rd = ^{fifo_out, fifo_empty, m_ready};
`endif

endmodule

// File: tb/tb_useq_fifo_bridge.sv
// Directed bench for useq_fifo_bridge: arbitration table plus multi-cycle sequences.
// Latency: not applicable.
// Backpressure: host and core are modelled by directly driven flags.
module tb_useq_fifo_bridge;

`ifdef USEQ_BRIDGE_READ_EN
    localparam logic RD_EN = 1'b1;
`else
    localparam logic RD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       write_fifo;
    logic       read_fifo;
    logic [7:0] fifo_in;
    logic [7:0] fifo_out;
    logic       fifo_empty = 1'b1;
    logic       fifo_full = 1'b0;
    logic       busy;
    logic [7:0] core_byte = 8'h00;

    int n_chk  = 0;
    int n_pass = 0;

    useq_fifo_bridge #(.POLL_GAP(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .write_fifo (write_fifo),
        .read_fifo  (read_fifo),
        .fifo_in    (fifo_in),
        .fifo_out   (fifo_out),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Core model: registers the requested byte on the edge that sees the strobe.
    always @(posedge clk) begin
        if (rst) fifo_out <= 8'h00;
        else if (read_fifo) fifo_out <= core_byte;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        s_valid    = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_full  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       sv;
        logic       full;
        logic       empty;
        logic [7:0] dat;
        logic       e_rdy;
        logic       e_wr;
        logic       e_rd;
        logic       e_busy;
    } vec_t;

    vec_t vecs[6];

    initial begin #500000; $display("FAIL watchdog: simulation did not finish"); $fatal; end

    initial begin
        int   bad;
        int   wcnt;
        int   nops;
        int   coinc;
        int   first_w;
        int   second_w;
        logic hs;
        logic [7:0] wdat;
        logic [3:0] ops;

        // Arbitration table, each applied from a fresh reset (write favoured).
        vecs[0] = '{1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0,  1'b1};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0,  1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, RD_EN, RD_EN};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h3D, 1'b1, 1'b1, 1'b0,  1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 8'hE7, 1'b0, 1'b0, RD_EN, RD_EN};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0,  1'b0};

        // Reset state.
        do_reset();
        chk1("rst write_fifo", write_fifo, 1'b0);
        chk1("rst read_fifo", read_fifo, 1'b0);
        chk8("rst fifo_in", fifo_in, 8'h00);
        chk1("rst m_valid", m_valid, 1'b0);
        chk8("rst m_data", m_data, 8'h00);
        chk1("rst busy", busy, 1'b0);
        chk1("rst s_ready", s_ready, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            s_valid    = vecs[i].sv;
            fifo_full  = vecs[i].full;
            fifo_empty = vecs[i].empty;
            s_data     = vecs[i].dat;
            #1;
            chk1($sformatf("vec%0d s_ready", i), s_ready, vecs[i].e_rdy);
            tick();
            chk1($sformatf("vec%0d write_fifo", i), write_fifo, vecs[i].e_wr);
            chk1($sformatf("vec%0d read_fifo", i), read_fifo, vecs[i].e_rd);
            chk1($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
            chk8($sformatf("vec%0d fifo_in", i), fifo_in, vecs[i].e_wr ? vecs[i].dat : 8'h00);
        end

        // Write path: one-cycle strobe, busy for WR plus two GAP cycles.
        do_reset();
        s_data = 8'hA5; s_valid = 1'b1;
        #1;
        chk1("wr s_ready", s_ready, 1'b1);
        chk1("wr busy idle", busy, 1'b0);
        tick();
        s_valid = 1'b0;
        chk1("wr strobe", write_fifo, 1'b1);
        chk8("wr fifo_in", fifo_in, 8'hA5);
        chk1("wr busy0", busy, 1'b1);
        chk1("wr s_ready busy", s_ready, 1'b0);
        tick();
        chk1("wr strobe off", write_fifo, 1'b0);
        chk1("wr busy1", busy, 1'b1);
        tick();
        chk1("wr busy2", busy, 1'b1);
        tick();
        chk1("wr busy3", busy, 1'b0);
        do_reset();
        chk8("rst clears fifo_in", fifo_in, 8'h00);

        // Write throughput: back-to-back writes spaced 2+POLL_GAP cycles.
        s_valid = 1'b1; s_data = 8'h42;
        wcnt = 0; first_w = -1; second_w = -1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (write_fifo) begin
                wcnt++;
                if (first_w < 0) first_w = i;
                else if (second_w < 0) second_w = i;
            end
        end
        chki("wr throughput count", wcnt, 4);
        chki("wr spacing", second_w - first_w, 4);

        // Full boundary: byte held by host, exactly one write after release.
        do_reset();
        s_valid = 1'b1; s_data = 8'h77; fifo_full = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s_ready) bad++;
            tick();
            if (write_fifo) bad++;
        end
        chki("full blocked", bad, 0);
        fifo_full = 1'b0;
        wcnt = 0; wdat = 8'h00;
        for (int i = 0; i < 12; i++) begin
            #1;
            hs = s_ready;
            tick();
            if (hs) s_valid = 1'b0;
            if (write_fifo) begin wcnt++; wdat = fifo_in; end
        end
        chki("full release writes", wcnt, 1);
        chk8("full release byte", wdat, 8'h77);
        chk1("full release idle", busy, 1'b0);

        // Contention: strobes alternate starting with write, never coincide.
        do_reset();
        s_valid = 1'b1; s_data = 8'h11; fifo_empty = 1'b0; m_ready = 1'b1; core_byte = 8'h22;
        nops = 0; coinc = 0; ops = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (write_fifo && read_fifo) coinc++;
            if (write_fifo && nops < 4) begin ops[nops] = 1'b1; nops++; end
            else if (read_fifo && nops < 4) begin ops[nops] = 1'b0; nops++; end
        end
        chki("cont coincide", coinc, 0);
        chki("cont ops seen", nops, 4);
        chk1("cont op0 W", ops[0], 1'b1);
        chk1("cont op1", ops[1], ~RD_EN);
        chk1("cont op2 W", ops[2], 1'b1);
        chk1("cont op3", ops[3], ~RD_EN);

`ifdef USEQ_BRIDGE_READ_EN
        // Read path: capture two cycles after the strobe, held until popped.
        do_reset();
        core_byte = 8'h3C; fifo_empty = 1'b0;
        #1;
        chk1("rd s_ready", s_ready, 1'b0);
        tick();
        chk1("rd strobe", read_fifo, 1'b1);
        chk1("rd busy", busy, 1'b1);
        fifo_empty = 1'b1;
        tick();
        chk1("rd strobe off", read_fifo, 1'b0);
        chk1("rd m_valid early", m_valid, 1'b0);
        tick();
        chk1("rd m_valid", m_valid, 1'b1);
        chk8("rd m_data", m_data, 8'h3C);
        core_byte = 8'hFF; fifo_empty = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!m_valid || m_data !== 8'h3C || read_fifo) bad++;
        end
        chki("rd hold stable, no read", bad, 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0; fifo_empty = 1'b1;
        chk1("rd pop clears", m_valid, 1'b0);

        // Reset during RCAP: no capture.
        do_reset();
        core_byte = 8'hC3; fifo_empty = 1'b0;
        tick();
        chk1("rstmid strobe", read_fifo, 1'b1);
        fifo_empty = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk1("rstmid read_fifo", read_fifo, 1'b0);
        chk1("rstmid m_valid", m_valid, 1'b0);
        chk1("rstmid busy", busy, 1'b0);
        rst = 1'b0;
        tick(); tick(); tick();
        chk1("rstmid no capture", m_valid, 1'b0);

        // Reset while the strobe is high drops it at that edge.
        do_reset();
        fifo_empty = 1'b0;
        tick();
        rst = 1'b1; fifo_empty = 1'b1;
        tick();
        chk1("rstrd strobe", read_fifo, 1'b0);
        chk1("rstrd busy", busy, 1'b0);
        rst = 1'b0;
`else
        // Write-only build: the read stimulus produces no read activity.
        do_reset();
        core_byte = 8'h3C; fifo_empty = 1'b0;
        bad = 0; wcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (read_fifo) bad++;
            if (m_valid || m_data !== 8'h00) wcnt++;
        end
        chki("noread strobe", bad, 0);
        chki("noread m_valid", wcnt, 0);
        chk1("noread busy", busy, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/useq_fifo_bridge.md
USEQ_FIFO_BRIDGE -- requirements
Module: useq_fifo_bridge

Interface
REQ-001 SHALL have parameter POLL_GAP, default 2, meaning the number of idle cycles after each host FIFO access (effective minimum 1) so the useq core can execute.
REQ-002 SHALL have the following ports, one per line (name, direction, width, meaning):
  clk  input  1  sole clock; all logic is on the rising edge
  rst  input  1  synchronous, active-high reset
  s_data  input  8  host-to-core byte
  s_valid  input  1  s_data is valid
  s_ready  output  1  s_data is accepted this cycle
  m_data  output  8  core-to-host byte
  m_valid  output  1  m_data is valid
  m_ready  input  1  host accepts m_data
  write_fifo  output  1  write strobe to the core message FIFO
  read_fifo  output  1  read strobe to the core message FIFO
  fifo_in  output  8  byte written to the core FIFO
  fifo_out  input  8  byte read from the core; registered by the core
  fifo_empty  input  1  core FIFO is empty; lags a strobe by 1 cycle
  fifo_full  input  1  core FIFO is full; lags a strobe by 1 cycle
  busy  output  1  state is not IDLE
REQ-003 SHALL drive write_fifo, read_fifo and fifo_in from registers.
REQ-004 SHALL never assert write_fifo and read_fifo in the same cycle.

Function
REQ-005 SHALL implement the states IDLE, WR, RD, RCAP and GAP.
REQ-006 In IDLE, SHALL form wr_cand = s_valid & !fifo_full and rd_cand = !hold_valid & !fifo_empty.
REQ-007 If only one candidate is true, SHALL select it; if both are true, SHALL select the op opposite to last_op (round-robin); after reset, last_op SHALL favour write.
REQ-008 SHALL make s_ready combinational, high only when state==IDLE and write is selected.
REQ-009 On the write handshake: fifo_in<=s_data, write_fifo<=1, last_op<=write, next state WR.
REQ-010 In WR: write_fifo<=0, next state GAP; the strobe is exactly 1 cycle wide.
REQ-011 On read select: read_fifo<=1, last_op<=read, next state RD.
REQ-012 In RD: read_fifo<=0, next state RCAP.
REQ-013 In RCAP: hold_data<=fifo_out, hold_valid<=1, next state GAP; the core byte is captured 2 cycles after the read_fifo rising edge.
REQ-014 GAP SHALL load a down-counter with max(POLL_GAP,1) on entry and return to IDLE when the counter expires; no strobes are driven and s_ready=0 during GAP.
REQ-015 GAP SHALL also cover the 1-cycle lag of fifo_empty/fifo_full, so flags are never sampled stale.
REQ-016 m_valid SHALL equal hold_valid and m_data SHALL equal hold_data; m_data SHALL stay stable while m_valid & !m_ready.
REQ-017 m_valid & m_ready SHALL clear hold_valid in any state; the clear is not blocked by RCAP, which only runs when hold_valid==0.
REQ-018 Full boundary: while fifo_full, s_ready SHALL stay 0 and the byte SHALL be held by the host without loss.
REQ-019 Empty boundary: while fifo_empty, no read strobe SHALL be issued.
REQ-020 Hold-full boundary: no read SHALL be issued while hold_valid=1.
REQ-021 Throughput: 1 write per 2+max(POLL_GAP,1) cycles; 1 read per 3+max(POLL_GAP,1) cycles.
REQ-022 busy SHALL equal (state != IDLE).

Reset
REQ-023 rst SHALL force, on the next edge: state=IDLE, write_fifo=0, read_fifo=0, fifo_in=0, hold_valid=0, hold_data=0, last_op=read-last (write favoured), GAP counter=0.
REQ-024 If rst occurs in WR/RD/RCAP, a pending strobe SHALL deassert at that edge and a byte in flight SHALL be discarded; the core is reset alongside.

Configuration
REQ-025 Macro USEQ_BRIDGE_READ_EN defined: the read path (RD, RCAP, hold register, m_* ports) SHALL be present.
REQ-026 Macro USEQ_BRIDGE_READ_EN undefined: read_fifo SHALL be tied 0, m_valid tied 0 and m_data tied 0, RD/RCAP SHALL be absent, and only writes SHALL be arbitrated; ports SHALL remain for pin compatibility.

Structure
REQ-027 Shared package useq_pkg SHALL hold the bridge state encoding (IDLE=0, WR=1, RD=2, RCAP=3, GAP=4) and the byte-width constant 8, both reused by useq-side tooling.
REQ-028 SHALL be a single flat module with no sub-modules; the GAP counter width is $clog2(POLL_GAP+1), minimum 1.

Verification
REQ-029 Write path: s_data=8'hA5 with s_valid=1, fifo_full=0 -> s_ready=1 for 1 cycle; next cycle write_fifo=1 with fifo_in=8'hA5 for exactly 1 cycle; busy=1 for 1+2 cycles (POLL_GAP=2).
REQ-030 Read path: fifo_empty=0, core model returns fifo_out=8'h3C one cycle after the strobe -> read_fifo pulses 1 cycle; m_valid=1 with m_data=8'h3C 2 cycles later, held stable until m_ready=1.
REQ-031 Full: fifo_full=1 with s_valid=1 for 20 cycles -> s_ready=0 and write_fifo=0 throughout; on release, exactly one write of the held byte.
REQ-032 Contention: s_valid=1 and fifo_empty=0 continuously, m_ready=1 -> strobes alternate W,R,W,R starting with W, and never coincide.
REQ-033 Reset mid-op: assert rst the cycle after read_fifo=1 -> read_fifo=0, m_valid=0, busy=0 at the next edge, and no capture occurs.
REQ-034 Macro undefined: same stimulus as REQ-030 -> read_fifo never asserts and m_valid stays 0.
